// File: rtl/renode_quiesce_pkg.sv
// Package for the Renode AXI quiesce controller.
// Contents:
//   state_e    - sequencer FSM states (RUN, DRAIN, RESET, HOLD)
//   cnt_width  - width needed for a counter that must hold values 0..max_val
package renode_quiesce_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    RESET = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Outstanding-transaction counter for one AXI direction of one master.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clr_i          - synchronous clear (takes priority over inc/dec)
//   inc_i          - request accepted downstream (valid & ready)
//   dec_i          - completion observed (B handshake or R last handshake)
//   cnt_o          - current outstanding count, 0..MaxTxn
//   full_o         - cnt_o == MaxTxn
//   underflow_o    - completion seen while count is 0 (and no inc this cycle)
// inc and dec in the same cycle leave the count unchanged. The count saturates
// at MaxTxn and at 0; the caller gates requests before the upper bound.
module axi_txn_counter #(
  parameter int MaxTxn = 8,
  parameter int CntW   = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            full_o,
  output logic            underflow_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !dec_i && (cnt_q != CntW'(MaxTxn))) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o       = cnt_q;
  assign full_o      = (cnt_q == CntW'(MaxTxn));
  assign underflow_o = dec_i && !inc_i && (cnt_q == '0);

endmodule

// File: rtl/renode_axi_quiesce_ctrl.sv
// Reset sequencer between NumMst AXI masters and the Renode memory bridge.
// On a Renode reset request it blocks new AW/AR, waits for all outstanding
// bursts to complete, puts the masters in reset and pulses rst_ack_o. When the
// request drops it keeps the masters in reset for HoldCycles, then frees them.
// Optional feature macro: RENODE_QUIESCE_TIMEOUT_EN (bounded drain, timeout_o).
// Ports:
//   clk_i, rst_ni                 - clock, asynchronous active-low reset
//   rst_req_i                     - Renode reset request (level)
//   rst_ack_o                     - one-cycle pulse on the first RESET cycle
//   core_rst_no[NumMst]           - per-master reset, active low
//   mst_/slv_ aw/ar valid/ready   - gated AW/AR request handshakes
//   b_hs_i, r_last_hs_i[NumMst]   - observed B / last-R handshakes
//   busy_o                        - some outstanding counter non-zero
//   err_o                         - sticky completion-without-request error
//   timeout_o                     - sticky drain timeout (0 without macro)
//   state_o                       - current FSM state, for debug
// Handshake rule: a request passes when valid & ready at the slave side; once
// slv_x_valid_o is high without ready it stays unblocked until accepted.
module renode_axi_quiesce_ctrl
  import renode_quiesce_pkg::*;
#(
  parameter int NumMst     = 2,
  parameter int MaxTxn     = 8,
  parameter int HoldCycles = 4,
  parameter int TimeoutCyc = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rst_req_i,
  output logic              rst_ack_o,
  output logic [NumMst-1:0] core_rst_no,
  input  logic [NumMst-1:0] mst_aw_valid_i,
  output logic [NumMst-1:0] slv_aw_valid_o,
  input  logic [NumMst-1:0] slv_aw_ready_i,
  output logic [NumMst-1:0] mst_aw_ready_o,
  input  logic [NumMst-1:0] mst_ar_valid_i,
  output logic [NumMst-1:0] slv_ar_valid_o,
  input  logic [NumMst-1:0] slv_ar_ready_i,
  output logic [NumMst-1:0] mst_ar_ready_o,
  input  logic [NumMst-1:0] b_hs_i,
  input  logic [NumMst-1:0] r_last_hs_i,
  output logic              busy_o,
  output logic              err_o,
  output logic              timeout_o,
  output state_e            state_o
);

  localparam int CntW  = cnt_width(MaxTxn);
  localparam int HoldW = cnt_width(HoldCycles);

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               ack_q, ack_d;
  logic               err_q;
  logic               cnt_clr;
  logic               run;
  logic               idle;

  logic [CntW-1:0]    aw_cnt [NumMst];
  logic [CntW-1:0]    ar_cnt [NumMst];
  logic [NumMst-1:0]  aw_full, ar_full, aw_uf, ar_uf;
  logic [NumMst-1:0]  aw_inc, ar_inc;
  logic [NumMst-1:0]  aw_stall_q, ar_stall_q;
  logic [NumMst-1:0]  aw_blk, ar_blk;

  // Block when not running or full, except for a request already on the bus.
  assign run    = (state_q == RUN);
  assign aw_blk = (~{NumMst{run}} | aw_full) & ~aw_stall_q;
  assign ar_blk = (~{NumMst{run}} | ar_full) & ~ar_stall_q;

  assign slv_aw_valid_o = mst_aw_valid_i & ~aw_blk;
  assign mst_aw_ready_o = slv_aw_ready_i & ~aw_blk;
  assign slv_ar_valid_o = mst_ar_valid_i & ~ar_blk;
  assign mst_ar_ready_o = slv_ar_ready_i & ~ar_blk;

  assign aw_inc = slv_aw_valid_o & slv_aw_ready_i;
  assign ar_inc = slv_ar_valid_o & slv_ar_ready_i;

  for (genvar m = 0; m < NumMst; m++) begin : g_cnt
    axi_txn_counter #(.MaxTxn(MaxTxn), .CntW(CntW)) u_aw_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (cnt_clr),
      .inc_i      (aw_inc[m]),
      .dec_i      (b_hs_i[m]),
      .cnt_o      (aw_cnt[m]),
      .full_o     (aw_full[m]),
      .underflow_o(aw_uf[m])
    );
    axi_txn_counter #(.MaxTxn(MaxTxn), .CntW(CntW)) u_ar_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (cnt_clr),
      .inc_i      (ar_inc[m]),
      .dec_i      (r_last_hs_i[m]),
      .cnt_o      (ar_cnt[m]),
      .full_o     (ar_full[m]),
      .underflow_o(ar_uf[m])
    );
  end

  always_comb begin
    busy_o = 1'b0;
    for (int m = 0; m < NumMst; m++) begin
      busy_o = busy_o | (aw_cnt[m] != '0) | (ar_cnt[m] != '0);
    end
  end

  // Drained: nothing outstanding and no request still being presented.
  assign idle = !busy_o && !(|slv_aw_valid_o) && !(|slv_ar_valid_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_stall_q <= '0;
      ar_stall_q <= '0;
      err_q      <= 1'b0;
    end else begin
      aw_stall_q <= slv_aw_valid_o & ~slv_aw_ready_i;
      ar_stall_q <= slv_ar_valid_o & ~slv_ar_ready_i;
      err_q      <= err_q | (|aw_uf) | (|ar_uf);
    end
  end

`ifdef RENODE_QUIESCE_TIMEOUT_EN
  localparam int TmoW = cnt_width(TimeoutCyc);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ack_d   = 1'b0;
    cnt_clr = 1'b0;
`ifdef RENODE_QUIESCE_TIMEOUT_EN
    tmo_d     = '0;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      RUN: begin
        if (rst_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (idle) begin
          state_d = RESET;
          ack_d   = 1'b1;
        end
`ifdef RENODE_QUIESCE_TIMEOUT_EN
        else if (tmo_q == TmoW'(TimeoutCyc - 1)) begin
          // Abandon the drain: outstanding bursts are forgotten.
          state_d   = RESET;
          ack_d     = 1'b1;
          cnt_clr   = 1'b1;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESET: begin
        hold_d = '0;
        if (!rst_req_i) state_d = HOLD;
      end
      HOLD: begin
        if (rst_req_i) begin
          state_d = RESET;
          ack_d   = 1'b1;
          hold_d  = '0;
        end else if (hold_q == HoldW'(HoldCycles - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      hold_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
    end
  end

`ifdef RENODE_QUIESCE_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Masters run during DRAIN so accepted bursts can finish.
  assign core_rst_no = (state_q == RUN || state_q == DRAIN) ? '1 : '0;
  assign rst_ack_o   = ack_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_renode_axi_quiesce_ctrl.sv
module tb_renode_axi_quiesce_ctrl;
  import renode_quiesce_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       rst_req_i;
  logic       rst_ack_o;
  logic [1:0] core_rst_no;
  logic [1:0] mst_aw_valid_i, slv_aw_valid_o, slv_aw_ready_i, mst_aw_ready_o;
  logic [1:0] mst_ar_valid_i, slv_ar_valid_o, slv_ar_ready_i, mst_ar_ready_o;
  logic [1:0] b_hs_i, r_last_hs_i;
  logic       busy_o, err_o, timeout_o;
  state_e     state_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  renode_axi_quiesce_ctrl #(
    .NumMst(2), .MaxTxn(8), .HoldCycles(4), .TimeoutCyc(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rst_req_i(rst_req_i), .rst_ack_o(rst_ack_o),
    .core_rst_no(core_rst_no),
    .mst_aw_valid_i(mst_aw_valid_i), .slv_aw_valid_o(slv_aw_valid_o),
    .slv_aw_ready_i(slv_aw_ready_i), .mst_aw_ready_o(mst_aw_ready_o),
    .mst_ar_valid_i(mst_ar_valid_i), .slv_ar_valid_o(slv_ar_valid_o),
    .slv_ar_ready_i(slv_ar_ready_i), .mst_ar_ready_o(mst_ar_ready_o),
    .b_hs_i(b_hs_i), .r_last_hs_i(r_last_hs_i),
    .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // Driver tasks: inputs change 1ns after a rising edge, outputs are read
  // 1ns later, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic aw_beat(input int m);
    mst_aw_valid_i[m] = 1'b1;
    slv_aw_ready_i[m] = 1'b1;
    step();
    mst_aw_valid_i[m] = 1'b0;
    slv_aw_ready_i[m] = 1'b0;
  endtask

  task automatic ar_beat(input int m);
    mst_ar_valid_i[m] = 1'b1;
    slv_ar_ready_i[m] = 1'b1;
    step();
    mst_ar_valid_i[m] = 1'b0;
    slv_ar_ready_i[m] = 1'b0;
  endtask

  // Drops the request and walks HOLD back to RUN (4 hold cycles).
  task automatic release_to_run();
    rst_req_i = 1'b0;
    step();
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; rst_req_i = 1'b0;
    mst_aw_valid_i = '0; slv_aw_ready_i = '0; mst_ar_valid_i = '0; slv_ar_ready_i = '0;
    b_hs_i = '0; r_last_hs_i = '0;
    #12;
    vectors++; if (core_rst_no !== 2'b00) begin miscompares++; $display("FAIL reset_core_rst act=%b exp=00", core_rst_no); end
    vectors++; if (state_o !== HOLD) begin miscompares++; $display("FAIL reset_state act=%0d exp=%0d", state_o, HOLD); end
    vectors++; if ({rst_ack_o, err_o, timeout_o, busy_o} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags act=%b exp=0000", {rst_ack_o, err_o, timeout_o, busy_o}); end
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      vectors++; if (core_rst_no !== 2'b00) begin miscompares++; $display("FAIL release_hold_%0d act=%b exp=00", i, core_rst_no); end
      @(posedge clk); #1;
    end
    vectors++; if (core_rst_no !== 2'b11) begin miscompares++; $display("FAIL release_run act=%b exp=11", core_rst_no); end
    vectors++; if (state_o !== RUN) begin miscompares++; $display("FAIL release_state act=%0d exp=%0d", state_o, RUN); end
  endtask

  task automatic test_drain();
    repeat (3) aw_beat(0);
    settle();
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL drain_busy act=%b exp=1", busy_o); end
    rst_req_i = 1'b1;
    step();
    vectors++; if (state_o !== DRAIN) begin miscompares++; $display("FAIL drain_state act=%0d exp=%0d", state_o, DRAIN); end
    vectors++; if (core_rst_no !== 2'b11) begin miscompares++; $display("FAIL drain_core_rst act=%b exp=11", core_rst_no); end
    mst_aw_valid_i[0] = 1'b1; slv_aw_ready_i[0] = 1'b1;
    settle();
    vectors++; if ({slv_aw_valid_o[0], mst_aw_ready_o[0]} !== 2'b00) begin miscompares++; $display("FAIL drain_aw_block act=%b exp=00", {slv_aw_valid_o[0], mst_aw_ready_o[0]}); end
    mst_aw_valid_i[0] = 1'b0; slv_aw_ready_i[0] = 1'b0;
    b_hs_i[0] = 1'b1;
    repeat (3) step();
    b_hs_i[0] = 1'b0;
    settle();
    vectors++; if (state_o !== DRAIN || rst_ack_o !== 1'b0) begin miscompares++; $display("FAIL drain_last_b act=%0d/%b exp=%0d/0", state_o, rst_ack_o, DRAIN); end
    step();
    vectors++; if (state_o !== RESET || rst_ack_o !== 1'b1) begin miscompares++; $display("FAIL drain_ack act=%0d/%b exp=%0d/1", state_o, rst_ack_o, RESET); end
    vectors++; if (core_rst_no !== 2'b00) begin miscompares++; $display("FAIL drain_reset_core act=%b exp=00", core_rst_no); end
    step();
    vectors++; if (rst_ack_o !== 1'b0 || state_o !== RESET) begin miscompares++; $display("FAIL drain_ack_pulse act=%b/%0d exp=0/%0d", rst_ack_o, state_o, RESET); end
    release_to_run();
    vectors++; if (state_o !== RUN || core_rst_no !== 2'b11) begin miscompares++; $display("FAIL drain_rerun act=%0d/%b exp=%0d/11", state_o, core_rst_no, RUN); end
  endtask

  task automatic test_stability();
    mst_aw_valid_i[1] = 1'b1; slv_aw_ready_i[1] = 1'b0; rst_req_i = 1'b1;
    settle();
    vectors++; if (slv_aw_valid_o[1] !== 1'b1) begin miscompares++; $display("FAIL stab_first act=%b exp=1", slv_aw_valid_o[1]); end
    step();
    vectors++; if (state_o !== DRAIN || slv_aw_valid_o[1] !== 1'b1) begin miscompares++; $display("FAIL stab_held act=%0d/%b exp=%0d/1", state_o, slv_aw_valid_o[1], DRAIN); end
    step();
    vectors++; if (slv_aw_valid_o[1] !== 1'b1) begin miscompares++; $display("FAIL stab_held2 act=%b exp=1", slv_aw_valid_o[1]); end
    slv_aw_ready_i[1] = 1'b1;
    settle();
    vectors++; if (mst_aw_ready_o[1] !== 1'b1) begin miscompares++; $display("FAIL stab_ready act=%b exp=1", mst_aw_ready_o[1]); end
    step();
    mst_aw_valid_i[1] = 1'b0; slv_aw_ready_i[1] = 1'b0;
    settle();
    vectors++; if (busy_o !== 1'b1 || state_o !== DRAIN) begin miscompares++; $display("FAIL stab_cnt1 act=%b/%0d exp=1/%0d", busy_o, state_o, DRAIN); end
    b_hs_i[1] = 1'b1;
    step();
    b_hs_i[1] = 1'b0;
    settle();
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL stab_cnt0 act=%b exp=0", busy_o); end
    step();
    vectors++; if (state_o !== RESET || rst_ack_o !== 1'b1) begin miscompares++; $display("FAIL stab_ack act=%0d/%b exp=%0d/1", state_o, rst_ack_o, RESET); end
    release_to_run();
  endtask

  task automatic test_saturation();
    repeat (8) ar_beat(0);
    mst_ar_valid_i[0] = 1'b1; slv_ar_ready_i[0] = 1'b1;
    settle();
    vectors++; if ({slv_ar_valid_o[0], mst_ar_ready_o[0]} !== 2'b00) begin miscompares++; $display("FAIL sat_gate act=%b exp=00", {slv_ar_valid_o[0], mst_ar_ready_o[0]}); end
    step();
    vectors++; if (slv_ar_valid_o[0] !== 1'b0) begin miscompares++; $display("FAIL sat_gate_hold act=%b exp=0", slv_ar_valid_o[0]); end
    r_last_hs_i[0] = 1'b1;
    step();
    settle();
    vectors++; if (slv_ar_valid_o[0] !== 1'b1) begin miscompares++; $display("FAIL sat_release act=%b exp=1", slv_ar_valid_o[0]); end
    step();
    r_last_hs_i[0] = 1'b0;
    settle();
    vectors++; if (slv_ar_valid_o[0] !== 1'b1) begin miscompares++; $display("FAIL sat_simul act=%b exp=1", slv_ar_valid_o[0]); end
    step();
    vectors++; if (slv_ar_valid_o[0] !== 1'b0) begin miscompares++; $display("FAIL sat_refull act=%b exp=0", slv_ar_valid_o[0]); end
    mst_ar_valid_i[0] = 1'b0; slv_ar_ready_i[0] = 1'b0;
    r_last_hs_i[0] = 1'b1;
    repeat (7) step();
    settle();
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL sat_one_left act=%b exp=1", busy_o); end
    step();
    r_last_hs_i[0] = 1'b0;
    settle();
    vectors++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin miscompares++; $display("FAIL sat_drained act=%b/%b exp=0/0", busy_o, err_o); end
  endtask

  task automatic test_underflow();
    b_hs_i[1] = 1'b1;
    step();
    b_hs_i[1] = 1'b0;
    settle();
    vectors++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin miscompares++; $display("FAIL uflow_set act=%b/%b exp=1/0", err_o, busy_o); end
    repeat (3) step();
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL uflow_sticky act=%b exp=1", err_o); end
    rst_ni = 1'b0;
    settle();
    vectors++; if (err_o !== 1'b0 || state_o !== HOLD || core_rst_no !== 2'b00) begin miscompares++; $display("FAIL uflow_clear act=%b/%0d/%b exp=0/%0d/00", err_o, state_o, core_rst_no, HOLD); end
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_hold_reack();
    step();
    rst_req_i = 1'b1;
    step();
    vectors++; if (state_o !== RESET || rst_ack_o !== 1'b1) begin miscompares++; $display("FAIL hold_reack act=%0d/%b exp=%0d/1", state_o, rst_ack_o, RESET); end
    release_to_run();
    vectors++; if (state_o !== RUN || core_rst_no !== 2'b11 || err_o !== 1'b0) begin miscompares++; $display("FAIL hold_rerun act=%0d/%b/%b exp=%0d/11/0", state_o, core_rst_no, err_o, RUN); end
  endtask

`ifdef RENODE_QUIESCE_TIMEOUT_EN
  task automatic test_timeout();
    aw_beat(0);
    rst_req_i = 1'b1;
    step();
    repeat (15) step();
    vectors++; if (state_o !== DRAIN || timeout_o !== 1'b0) begin miscompares++; $display("FAIL tmo_before act=%0d/%b exp=%0d/0", state_o, timeout_o, DRAIN); end
    step();
    vectors++; if (state_o !== RESET || timeout_o !== 1'b1 || busy_o !== 1'b0) begin miscompares++; $display("FAIL tmo_fire act=%0d/%b/%b exp=%0d/1/0", state_o, timeout_o, busy_o, RESET); end
    release_to_run();
  endtask
`endif

  initial begin
    test_reset();
    test_drain();
    test_stability();
    test_saturation();
    test_underflow();
    test_hold_reack();
`ifdef RENODE_QUIESCE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
